// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the pipelined CPU front end: the fetch unit, the decode
// unit and the branch unit all agree on address/data widths, the sequential PC
// increment and the post-reset fetch address.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int          CPU_ADDR_W   = 32;
    localparam int          CPU_DATA_W   = 32;
    localparam int          PC_STEP      = 4;
    localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// -----------------------------------------------------------------------------
// if_fifo
// Synchronous prefetch FIFO holding {pc, instruction} entries.
//
// Ports:
//   clk    in   rising-edge clock
//   clrn   in   asynchronous active-low reset (empties the FIFO)
//   push   in   write wdata at the tail
//   wdata  in   entry to write
//   pop    in   remove the head entry
//   flush  in   synchronous empty; wins over push and pop
//   rdata  out  head entry (meaningful only while !empty)
//   count  out  number of stored entries, 0..DEPTH
//   empty  out  count == 0
//   full   out  count == DEPTH
// -----------------------------------------------------------------------------
module if_fifo
    import cpu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic                    push,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    pop,
    input  logic                    flush,
    output logic [WIDTH-1:0]        rdata,
    output logic [occ_w(DEPTH)-1:0] count,
    output logic                    empty,
    output logic                    full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = occ_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no control meaning, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// -----------------------------------------------------------------------------
// if_prefetch_unit
// Pipelined instruction-fetch stage: registered fetch PC, one-cycle-latency
// synchronous instruction memory, prefetch FIFO and a valid/ready handshake
// toward decode. A redirect flushes queued and in-flight fetches and restarts
// fetching at the new word-aligned address.
//
// Ports:
//   clk          in   rising-edge clock
//   clrn         in   asynchronous active-low reset
//   redirect     in   branch/jump taken: flush and restart fetch
//   redirect_pc  in   restart address (bits [1:0] ignored)
//   imem_req     out  read request this cycle
//   imem_addr    out  word-aligned read address
//   imem_rdata   in   read data, valid the cycle after imem_req
//   inst_valid   out  FIFO head holds an instruction
//   inst_ready   in   decode accepts the head this cycle
//   inst         out  instruction at the head (0 when not valid)
//   inst_pc      out  address of inst (0 when not valid)
//   inst_pc4     out  inst_pc + 4 modulo 2^ADDR_W (0 when not valid)
// -----------------------------------------------------------------------------
module if_prefetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = CPU_ADDR_W,
    parameter int                DATA_W     = CPU_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(CPU_RESET_PC),
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] inst_pc4
);

    localparam int CW    = occ_w(FIFO_DEPTH);
    localparam int WIDTH = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q;

    logic [CW-1:0]     fifo_count;
    logic [CW:0]       occupancy;
    logic              fifo_empty;
    logic              fifo_full;
    logic [WIDTH-1:0]  fifo_rdata;
    logic              resp_push;
    logic              head_pop;
    logic              can_issue;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_inst;

    // Credit: queued entries plus the outstanding read never exceed the FIFO
    // depth, so every response is guaranteed a free slot.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign can_issue = clrn & ~redirect & (occupancy < (CW+1)'(FIFO_DEPTH));

    assign imem_req  = can_issue;
    assign imem_addr = fetch_pc_q;

    // A redirect kills the response landing this cycle and ignores any pop:
    // decode discards that instruction because it is younger than the branch.
    assign resp_push = inflight_q & ~redirect;
    assign head_pop  = inst_valid & inst_ready & ~redirect;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = 1'b0;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (can_issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
        end
    end

    // Only consulted while inflight_q is set, so no reset needed.
    always_ff @(posedge clk) begin
        if (can_issue) begin
            inflight_pc_q <= fetch_pc_q;
        end
    end

    if_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (resp_push),
        .wdata ({inflight_pc_q, imem_rdata}),
        .pop   (head_pop),
        .flush (redirect),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign {head_pc, head_inst} = fifo_rdata;

    // Outputs are forced to zero whenever the head is empty, which also covers reset.
    assign inst_valid = ~fifo_empty;
    assign inst       = inst_valid ? head_inst : '0;
    assign inst_pc    = inst_valid ? head_pc   : '0;
    assign inst_pc4   = inst_valid ? head_pc + ADDR_W'(PC_STEP) : '0;

    a_no_overflow : assert property (@(posedge clk) disable iff (!clrn)
        !(resp_push && fifo_full))
        else $error("prefetch FIFO overflow");

endmodule

// File: tb/tb_if_prefetch_unit.sv
module tb_if_prefetch_unit;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        clrn;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;

  if_prefetch_unit #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_pc4    (inst_pc4)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of fetched PCs visible to decode, one outstanding read.
  logic [31:0] m_q[$];
  bit          m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_fetch_pc;

  // Last-cycle observations and logs used by directed checks.
  bit          o_req;
  bit          o_valid;
  logic [31:0] o_addr;
  logic [31:0] o_pc;
  logic [31:0] o_pc4;
  logic [31:0] dl[$];
  logic [31:0] rq[$];

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_infl     = 1'b0;
    m_infl_pc  = '0;
    m_fetch_pc = RPC;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle(input bit rd, input bit ry, input logic [31:0] rpc);
    bit          exp_req;
    bit          exp_valid;
    logic [31:0] exp_pc4;
    logic [31:0] s_addr;
    bit          s_req;
    redirect    = rd;
    inst_ready  = ry;
    redirect_pc = rpc;
    #1;
    exp_req   = !rd && ((m_q.size() + int'(m_infl)) < DEPTH);
    exp_valid = (m_q.size() > 0);
    check_eq("imem_req", imem_req, exp_req);
    if (exp_req) check_eq("imem_addr", imem_addr, m_fetch_pc);
    check_eq("inst_valid", inst_valid, exp_valid);
    if (exp_valid) begin
      exp_pc4 = m_q[0] + 32'd4;
      check_eq("inst_pc", inst_pc, m_q[0]);
      check_eq("inst", inst, rom(m_q[0]));
      check_eq("inst_pc4", inst_pc4, exp_pc4);
    end
    o_req   = imem_req;
    o_addr  = imem_addr;
    o_valid = inst_valid;
    o_pc    = inst_pc;
    o_pc4   = inst_pc4;
    s_req   = imem_req;
    s_addr  = imem_addr;
    if (s_req) rq.push_back(s_addr);
    if (!rd && ry && inst_valid) dl.push_back(inst_pc);
    if (rd) begin
      m_q.delete();
      m_infl     = 1'b0;
      m_fetch_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      if (exp_valid && ry) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_infl_pc);
      m_infl    = exp_req;
      m_infl_pc = m_fetch_pc;
      if (exp_req) m_fetch_pc = m_fetch_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    imem_rdata = s_req ? rom(s_addr) : $urandom;
    @(negedge clk);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    redirect = 1'b0;
    clrn = 1'b0;
    #1;
    check_eq("rst_imem_req", imem_req, 1'b0);
    check_eq("rst_inst_valid", inst_valid, 1'b0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_inst_pc", inst_pc, 32'h0);
    check_eq("rst_inst_pc4", inst_pc4, 32'h0);
    #1;
    clrn = 1'b1;
    model_reset();
  endtask

  initial begin
    int          cnt;
    logic [31:0] first_pc;
    bit          seen;
    int          r;
    logic [31:0] rpc;

    clrn        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b0;
    imem_rdata  = '0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("rst_imem_req", imem_req, 1'b0);
      check_eq("rst_inst_valid", inst_valid, 1'b0);
      check_eq("rst_inst_pc", inst_pc, 32'h0);
    end
    clrn = 1'b1;

    // Scenario 1: streaming from reset with decode always ready.
    rq.delete(); dl.delete();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, '0);
      if (i == 1) check_eq("s1_valid_c1", o_valid, 1'b0);
      if (i == 2) begin
        check_eq("s1_valid_c2", o_valid, 1'b1);
        check_eq("s1_pc_c2", o_pc, RPC);
      end
    end
    check_eq("s1_req_count", rq.size(), 8);
    for (int i = 0; i < 4; i++) check_eq("s1_addr_seq", rq[i], RPC + 32'(4 * i));
    check_eq("s1_dl_count", dl.size(), 6);
    for (int i = 0; i < 3; i++) check_eq("s1_pc_seq", dl[i], RPC + 32'(4 * i));

    // Scenario 2: decode stalled from reset.
    reset_pulse();
    rq.delete();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0);
    check_eq("s2_req_count", rq.size(), DEPTH);
    check_eq("s2_head_pc", o_pc, RPC);
    rq.delete();
    cycle(1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0);
    check_eq("s2_refill_count", rq.size(), 1);
    if (rq.size() > 0) check_eq("s2_refill_addr", rq[0], RPC + 32'h10);

    // Scenario 3: redirect with three queued and one in flight.
    reset_pulse();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'h0000_0103);
    cycle(1'b0, 1'b1, '0);
    check_eq("s3_valid_n1", o_valid, 1'b0);
    check_eq("s3_req_n1", o_req, 1'b1);
    check_eq("s3_addr_n1", o_addr, 32'h100);
    cycle(1'b0, 1'b1, '0);
    check_eq("s3_valid_n2", o_valid, 1'b0);
    cycle(1'b0, 1'b1, '0);
    check_eq("s3_valid_n3", o_valid, 1'b1);
    check_eq("s3_pc_n3", o_pc, 32'h100);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, '0);
      check_eq("s3_no_stale", o_valid && (o_pc < 32'h100), 1'b0);
    end

    // Scenario 4: back-to-back redirects, last wins.
    cycle(1'b1, 1'b1, 32'h0000_0200);
    cycle(1'b1, 1'b1, 32'h0000_0300);
    rq.delete(); dl.delete();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, '0);
    cnt = 0;
    foreach (rq[i]) if (rq[i] == 32'h200) cnt++;
    check_eq("s4_no_req_200", cnt, 0);
    check_eq("s4_dl_nonempty", dl.size() > 0, 1'b1);
    if (dl.size() > 0) check_eq("s4_first_pc", dl[0], 32'h300);

    // Scenario 5: address wrap at the top of the address space.
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
    dl.delete();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, '0);
      if (o_valid && o_pc == 32'hFFFF_FFFC) begin
        seen = 1'b1;
        check_eq("s5_pc4_wrap", o_pc4, 32'h0);
      end
    end
    check_eq("s5_seen_fffc", seen, 1'b1);
    check_eq("s5_dl_count", dl.size() >= 3, 1'b1);
    if (dl.size() >= 3) begin
      check_eq("s5_pc0", dl[0], 32'hFFFF_FFF8);
      check_eq("s5_pc1", dl[1], 32'hFFFF_FFFC);
      check_eq("s5_pc2", dl[2], 32'h0000_0000);
    end

    // Scenario 6: asynchronous reset mid-stream, then the reset latency again.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0);
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, '0);
      if (i == 0) begin
        check_eq("s6_req_c0", o_req, 1'b1);
        check_eq("s6_addr_c0", o_addr, RPC);
      end
      if (i == 1) check_eq("s6_valid_c1", o_valid, 1'b0);
      if (i == 2) begin
        check_eq("s6_valid_c2", o_valid, 1'b1);
        check_eq("s6_pc_c2", o_pc, RPC);
      end
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) reset_pulse();
      r = $urandom_range(0, 3);
      if (r == 0)      rpc = $urandom;
      else if (r == 1) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else             rpc = 32'($urandom_range(0, 255));
      cycle($urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0, rpc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
Parametrised pipelined instruction-fetch stage. It replaces the combinational PC+4/ROM fetch with a registered PC, a synchronous instruction-memory interface with one-cycle read latency, and a prefetch FIFO. A valid/ready handshake feeds the decode stage. Branch/jump redirect flushes all queued and in-flight fetches. It sits between the PC-select logic of the pipelined CPU and the IF/ID boundary.

Parameters:
ADDR_W, 32, PC/instruction address width
DATA_W, 32, instruction word width
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 4, prefetch buffer entries (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
clrn  in  1  asynchronous active-low reset
redirect  in  1  branch/jump taken; flush and restart fetch
redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored, treated as 0
imem_req  out  1  read request to instruction memory this cycle
imem_addr  out  ADDR_W  word-aligned read address
imem_rdata  in  DATA_W  read data, valid in the cycle after imem_req
inst_valid  out  1  FIFO head holds an instruction
inst_ready  in  1  decode accepts the head this cycle
inst  out  DATA_W  instruction at FIFO head
inst_pc  out  ADDR_W  address of inst
inst_pc4  out  ADDR_W  inst_pc + 4, modulo 2^ADDR_W

Behaviour:
- Reset (clrn low, asynchronous): fetch_pc=RESET_PC; FIFO empty; in-flight flag cleared. While clrn is low: imem_req=0, inst_valid=0, inst/inst_pc/inst_pc4=0.
- Issue condition: can_issue = clrn & !redirect & (count + inflight < FIFO_DEPTH). imem_req=can_issue; imem_addr=fetch_pc.
  - On issue: fetch_pc <= fetch_pc + 4 (wraps at 2^ADDR_W); inflight<=1; inflight_pc<=fetch_pc. Otherwise inflight<=0.
- Response: in the cycle after an issue, imem_rdata is pushed with inflight_pc. It becomes visible at the head on the next edge. Issue-to-inst_valid latency is 2 cycles.
- Pop: when inst_valid & inst_ready, the head is removed. Push and pop in the same cycle are both honoured, and count is unchanged.
- Credit rule: count + inflight never exceeds FIFO_DEPTH, so a push never finds the FIFO full. Overflow is impossible by construction. An assertion checks it.
- Redirect (highest priority):
  - Same edge: FIFO flushed (count=0); inflight cleared; the response arriving that cycle is discarded; fetch_pc <= {redirect_pc[ADDR_W-1:2],2'b00}.
  - No imem_req in the redirect cycle. The first request to redirect_pc is in cycle N+1, and inst_valid rises in N+3.
  - A pop in the redirect cycle is ignored. The handshake still completes for decode, but decode must drop it, because redirect kills younger instructions.
  - Back-to-back redirects: the last one wins, and each one restarts the latency.
- Stall: inst_ready=0 holds inst/inst_pc stable while inst_valid=1. Fetch continues until count + inflight = FIFO_DEPTH, then imem_req=0 until a pop.
- inst_pc4 = inst_pc + 4 using ADDR_W-bit unsigned arithmetic. It is 0 at 0xFFFF_FFFC.
- After clrn deasserts, the first imem_req is in cycle 0 with addr RESET_PC, and inst_valid is high in cycle 2.

Decomposition:
- Shared package cpu_pkg: PC_STEP=4, RESET_PC default, and the ADDR_W/DATA_W defaults, shared with the decode and branch units.
- One sub-module, if_fifo: a synchronous FIFO with parameters WIDTH (=DATA_W+ADDR_W) and DEPTH. It has push, pop, flush, an async active-low clrn, and count, empty and full outputs.
- PC register, credit logic and redirect handling live in the top module.

Test Plan:
1. Reset release, inst_ready=1, ROM word[i]=i:
   - imem_addr is 0,4,8,… from cycle 0.
   - inst_valid=1 from cycle 2, with inst=0,1,2 and inst_pc=0,4,8, one per cycle.
2. inst_ready=0 from reset, FIFO_DEPTH=4:
   - Exactly 4 requests are issued (addr 0..C), then imem_req=0 and the head holds inst_pc=0.
   - Raising inst_ready for 1 cycle triggers exactly one new request, to addr 0x10.
3. redirect=1 with redirect_pc=0x103 while 3 entries are queued and 1 is in flight:
   - Next cycle: inst_valid=0 and imem_addr=0x100.
   - inst_valid returns 2 cycles later with inst_pc=0x100, and no stale PC ever appears.
4. Redirect in two consecutive cycles, to 0x200 then 0x300:
   - The first fetched PC is 0x300.
   - 0x200 is never requested after the second redirect, and never delivered.
5. redirect_pc=0xFFFF_FFF8 with inst_ready=1:
   - inst_pc sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
   - inst_pc4 at FFFF_FFFC is 0.
6. clrn pulsed low mid-stream between clock edges:
   - inst_valid and imem_req drop immediately.
   - After release, fetch restarts at RESET_PC with the latency of scenario 1.
